// File: rtl/fifo_uart_tx_pkg.sv
// Shared types for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  localparam logic TX_IDLE_LVL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the async FIFO read side and its consumer.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;

  // master = consumer popping the FIFO, slave = FIFO read side
  modport master (input rempty, input rdata, output rinc);
  modport slave  (output rempty, output rdata, input rinc);
endinterface

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: modulo-CLKS_PER_BIT counter with a terminal-count tick.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops one word per frame and serializes it
// LSB first with optional parity, pacing FIFO pops to the line rate.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic PAR_ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] data);
    return (^data) ^ PAR_ODD_BIT;
  endfunction

  uart_tx_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;

  logic                  tick_s;
  logic                  pop_s;
  logic                  last_stop_s;
  logic                  baud_clr_s;
  logic [DATA_WIDTH-1:0] shreg_shift_s;

  // Counter is held at zero while idle so the first bit gets a full period.
  assign baud_clr_s = pop_s | (state_q == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (baud_clr_s),
    .tick  (tick_s)
  );

  assign last_stop_s   = (state_q == STOP) & tick_s & (bit_cnt_q == LAST_STOP);
  // rst_n gating keeps rinc low while reset is held with a non-empty FIFO.
  assign pop_s         = rst_n & en & ~fifo.rempty & ((state_q == IDLE) | last_stop_s);
  assign shreg_shift_s = {1'b0, shreg_q[DATA_WIDTH-1:1]};

  assign fifo.rinc = pop_s;
  assign busy      = pop_s | (state_q != IDLE);
  assign tx        = tx_q;

  // Next-state logic: a pop always wins, otherwise advance on bit-period ticks.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tx_d      = tx_q;
    if (pop_s) begin
      state_d   = START;
      shreg_d   = fifo.rdata;
      par_d     = frame_parity(fifo.rdata);
      bit_cnt_d = '0;
      tx_d      = 1'b0;
    end else if (tick_s) begin
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shreg_q[0];
        end
        DATA: begin
          shreg_d = shreg_shift_s;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = TX_IDLE_LVL;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_d      = shreg_shift_s[0];
          end
        end
        PARITY: begin
          state_d   = STOP;
          bit_cnt_d = '0;
          tx_d      = TX_IDLE_LVL;
        end
        STOP: begin
          tx_d = TX_IDLE_LVL;
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
        IDLE: begin
          tx_d = TX_IDLE_LVL;
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          tx_d      = TX_IDLE_LVL;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers; reset drives the line back to idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= TX_IDLE_LVL;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: three instances cover even parity,
// odd parity and no parity at CLKS_PER_BIT=4.
module tb_fifo_uart_tx;

  logic clk;
  logic rst_n;
  logic en_a, en_b, en_c;
  logic tx_a, tx_b, tx_c;
  logic busy_a, busy_b, busy_c;

  int n_checks;
  int n_fails;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  logic tx_log   [0:199];
  logic busy_log [0:199];
  logic rinc_log [0:199];
  int   sel;

  fifo_uart_tx_if #(.DATA_WIDTH(8)) if_a ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) if_b ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) if_c ();

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .en(en_a), .fifo(if_a), .tx(tx_a), .busy(busy_a));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    dut_b (.clk(clk), .rst_n(rst_n), .en(en_b), .fifo(if_b), .tx(tx_b), .busy(busy_b));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut_c (.clk(clk), .rst_n(rst_n), .en(en_c), .fifo(if_c), .tx(tx_c), .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic sync_fifos();
    if_a.rempty = (qa.size() == 0);
    if_a.rdata  = (qa.size() != 0) ? qa[0] : 8'h00;
    if_b.rempty = (qb.size() == 0);
    if_b.rdata  = (qb.size() != 0) ? qb[0] : 8'h00;
    if_c.rempty = (qc.size() == 0);
    if_c.rdata  = (qc.size() != 0) ? qc[0] : 8'h00;
  endtask

  // Runs n cycles; logs the selected instance mid-cycle and models FIFO pops.
  task automatic record(input int n);
    logic pa, pb, pc;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pa = if_a.rinc;
      pb = if_b.rinc;
      pc = if_c.rinc;
      case (sel)
        0: begin tx_log[k] = tx_a; busy_log[k] = busy_a; rinc_log[k] = pa; end
        1: begin tx_log[k] = tx_b; busy_log[k] = busy_b; rinc_log[k] = pb; end
        default: begin tx_log[k] = tx_c; busy_log[k] = busy_c; rinc_log[k] = pc; end
      endcase
      @(posedge clk);
      #1;
      if (pa && qa.size() != 0) void'(qa.pop_front());
      if (pb && qb.size() != 0) void'(qb.pop_front());
      if (pc && qc.size() != 0) void'(qc.pop_front());
      sync_fifos();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    sync_fifos();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tx_a !== 1'b1) begin n_fails++; $display("FAIL reset_tx: got %b expected 1", tx_a); end
    n_checks++;
    if (busy_a !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    n_checks++;
    if (if_a.rinc !== 1'b0) begin n_fails++; $display("FAIL reset_rinc: got %b expected 0", if_a.rinc); end
    n_checks++;
    if ({tx_b, tx_c, busy_b, busy_c} !== 4'b1100) begin
      n_fails++; $display("FAIL reset_bc: got %b expected 1100", {tx_b, tx_c, busy_b, busy_c});
    end
    rst_n = 1'b1;
    record(2);
  endtask

  task automatic test_single_frame();
    logic [10:0] exp;
    int nr, nb;
    exp = {1'b1, 1'b0, 8'hA5, 1'b0};
    sel = 0;
    qa.push_back(8'hA5);
    sync_fifos();
    en_a = 1'b1;
    record(60);
    nr = 0; nb = 0;
    for (int k = 0; k < 60; k++) begin
      if (rinc_log[k] === 1'b1) nr++;
      if (busy_log[k] === 1'b1) nb++;
    end
    n_checks++;
    if (rinc_log[0] !== 1'b1) begin n_fails++; $display("FAIL single_pop_cycle: got %b expected 1", rinc_log[0]); end
    n_checks++;
    if (nr != 1) begin n_fails++; $display("FAIL single_rinc_count: got %0d expected 1", nr); end
    n_checks++;
    if (nb != 45) begin n_fails++; $display("FAIL single_busy_len: got %0d expected 45", nb); end
    n_checks++;
    if (busy_log[45] !== 1'b0) begin n_fails++; $display("FAIL single_busy_end: got %b expected 0", busy_log[45]); end
    n_checks++;
    if (tx_log[0] !== 1'b1) begin n_fails++; $display("FAIL single_tx_popcycle: got %b expected 1", tx_log[0]); end
    for (int k = 1; k <= 44; k++) begin
      n_checks++;
      if (tx_log[k] !== exp[(k-1)/4]) begin
        n_fails++; $display("FAIL single_tx cycle %0d: got %b expected %b", k, tx_log[k], exp[(k-1)/4]);
      end
    end
    n_checks++;
    if (tx_log[59] !== 1'b1) begin n_fails++; $display("FAIL single_tx_idle: got %b expected 1", tx_log[59]); end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp;
    int nr, nb;
    exp = {1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0};
    sel = 0;
    qa.push_back(8'h01);
    qa.push_back(8'h80);
    sync_fifos();
    en_a = 1'b1;
    record(100);
    nr = 0; nb = 0;
    for (int k = 0; k < 100; k++) begin
      if (rinc_log[k] === 1'b1) nr++;
      if (busy_log[k] === 1'b1) nb++;
    end
    n_checks++;
    if (rinc_log[44] !== 1'b1) begin n_fails++; $display("FAIL b2b_second_pop: got %b expected 1", rinc_log[44]); end
    n_checks++;
    if (nr != 2) begin n_fails++; $display("FAIL b2b_rinc_count: got %0d expected 2", nr); end
    n_checks++;
    if (nb != 89) begin n_fails++; $display("FAIL b2b_busy_len: got %0d expected 89", nb); end
    n_checks++;
    if (busy_log[89] !== 1'b0) begin n_fails++; $display("FAIL b2b_busy_end: got %b expected 0", busy_log[89]); end
    for (int k = 1; k <= 88; k++) begin
      n_checks++;
      if (tx_log[k] !== exp[(k-1)/4]) begin
        n_fails++; $display("FAIL b2b_tx cycle %0d: got %b expected %b", k, tx_log[k], exp[(k-1)/4]);
      end
    end
    n_checks++;
    if (qa.size() != 0) begin n_fails++; $display("FAIL b2b_fifo_drained: got %0d expected 0", qa.size()); end
  endtask

  task automatic test_parity_variants();
    logic [10:0] exp_odd;
    logic [9:0]  exp_none;
    int nb;
    exp_odd  = {1'b1, 1'b0, 8'h07, 1'b0};
    exp_none = {1'b1, 8'h07, 1'b0};
    sel = 1;
    qb.push_back(8'h07);
    sync_fifos();
    en_b = 1'b1;
    record(60);
    nb = 0;
    for (int k = 0; k < 60; k++) if (busy_log[k] === 1'b1) nb++;
    for (int k = 1; k <= 44; k++) begin
      n_checks++;
      if (tx_log[k] !== exp_odd[(k-1)/4]) begin
        n_fails++; $display("FAIL odd_tx cycle %0d: got %b expected %b", k, tx_log[k], exp_odd[(k-1)/4]);
      end
    end
    n_checks++;
    if (nb != 45) begin n_fails++; $display("FAIL odd_busy_len: got %0d expected 45", nb); end

    sel = 2;
    qc.push_back(8'h07);
    sync_fifos();
    en_c = 1'b1;
    record(60);
    nb = 0;
    for (int k = 0; k < 60; k++) if (busy_log[k] === 1'b1) nb++;
    for (int k = 1; k <= 40; k++) begin
      n_checks++;
      if (tx_log[k] !== exp_none[(k-1)/4]) begin
        n_fails++; $display("FAIL nopar_tx cycle %0d: got %b expected %b", k, tx_log[k], exp_none[(k-1)/4]);
      end
    end
    n_checks++;
    if (nb != 41) begin n_fails++; $display("FAIL nopar_busy_len: got %0d expected 41", nb); end
    n_checks++;
    if (busy_log[41] !== 1'b0) begin n_fails++; $display("FAIL nopar_busy_end: got %b expected 0", busy_log[41]); end
  endtask

  task automatic test_empty();
    int nr, nb, nt;
    sel = 0;
    en_a = 1'b1;
    sync_fifos();
    record(100);
    nr = 0; nb = 0; nt = 0;
    for (int k = 0; k < 100; k++) begin
      if (rinc_log[k] !== 1'b0) nr++;
      if (busy_log[k] !== 1'b0) nb++;
      if (tx_log[k] !== 1'b1) nt++;
    end
    n_checks++;
    if (nr != 0) begin n_fails++; $display("FAIL empty_rinc: got %0d pulses expected 0", nr); end
    n_checks++;
    if (nb != 0) begin n_fails++; $display("FAIL empty_busy: got %0d busy cycles expected 0", nb); end
    n_checks++;
    if (nt != 0) begin n_fails++; $display("FAIL empty_tx: got %0d low cycles expected 0", nt); end
  endtask

  task automatic test_enable_hold();
    int nr, nb;
    sel = 0;
    qa.push_back(8'h3C);
    qa.push_back(8'h55);
    sync_fifos();
    en_a = 1'b1;
    record(10);
    n_checks++;
    if (rinc_log[0] !== 1'b1) begin n_fails++; $display("FAIL hold_first_pop: got %b expected 1", rinc_log[0]); end
    en_a = 1'b0;
    record(60);
    nr = 0; nb = 0;
    for (int k = 0; k < 60; k++) begin
      if (rinc_log[k] === 1'b1) nr++;
      if (busy_log[k] === 1'b1) nb++;
    end
    n_checks++;
    if (nr != 0) begin n_fails++; $display("FAIL hold_no_pop: got %0d expected 0", nr); end
    n_checks++;
    if (nb != 35) begin n_fails++; $display("FAIL hold_frame_completes: got %0d expected 35", nb); end
    n_checks++;
    if (qa.size() != 1) begin n_fails++; $display("FAIL hold_fifo_level: got %0d expected 1", qa.size()); end
    en_a = 1'b1;
    record(50);
    n_checks++;
    if (rinc_log[0] !== 1'b1) begin n_fails++; $display("FAIL hold_resume_pop: got %b expected 1", rinc_log[0]); end
    n_checks++;
    if (qa.size() != 0) begin n_fails++; $display("FAIL hold_resume_drain: got %0d expected 0", qa.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] exp;
    exp = {1'b1, 1'b0, 8'h33, 1'b0};
    sel = 0;
    qa.push_back(8'h00);
    qa.push_back(8'h33);
    sync_fifos();
    en_a = 1'b1;
    record(20);
    n_checks++;
    if ({tx_a, busy_a} !== 2'b01) begin n_fails++; $display("FAIL midrst_before: got %b expected 01", {tx_a, busy_a}); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_a !== 1'b1) begin n_fails++; $display("FAIL midrst_tx_async: got %b expected 1", tx_a); end
    n_checks++;
    if (busy_a !== 1'b0) begin n_fails++; $display("FAIL midrst_busy_async: got %b expected 0", busy_a); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (if_a.rinc !== 1'b0) begin n_fails++; $display("FAIL midrst_rinc_held: got %b expected 0", if_a.rinc); end
    rst_n = 1'b1;
    record(50);
    n_checks++;
    if (rinc_log[0] !== 1'b1) begin n_fails++; $display("FAIL midrst_fresh_pop: got %b expected 1", rinc_log[0]); end
    for (int k = 1; k <= 44; k++) begin
      n_checks++;
      if (tx_log[k] !== exp[(k-1)/4]) begin
        n_fails++; $display("FAIL midrst_tx cycle %0d: got %b expected %b", k, tx_log[k], exp[(k-1)/4]);
      end
    end
    n_checks++;
    if (busy_log[45] !== 1'b0) begin n_fails++; $display("FAIL midrst_busy_end: got %b expected 0", busy_log[45]); end
    n_checks++;
    if (qa.size() != 0) begin n_fails++; $display("FAIL midrst_fifo_level: got %0d expected 0", qa.size()); end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    sel      = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity_variants();
    test_empty();
    test_enable_hold();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
